// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants and helpers for the common data bus arbiter.
//   DEF_ROB_BIT     default ROB tag width
//   CDB_FIFO_DEPTH  default entries per source FIFO
//   src_e           bus source encoding (SRC_ALU = 0, SRC_LSB = 1)
//   pick_source()   round-robin winner between the two FIFO heads
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int DEF_ROB_BIT    = 4;
   localparam int CDB_FIFO_DEPTH = 2;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } src_e;

   // With both heads present the source that did not win last time goes next;
   // with one head present it wins outright. The result is only meaningful
   // when at least one head exists.
   function automatic src_e pick_source(input logic has_alu,
                                        input logic has_lsb,
                                        input src_e last_grant);
      if (has_alu && has_lsb)
         return (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
      else if (has_lsb)
         return SRC_LSB;
      else
         return SRC_ALU;
   endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Circular buffer of completed results for one CDB source.
//   clk_in, rst_in   clock, asynchronous active-high reset
//   push, din        write one entry (caller guarantees !full)
//   pop, dout        remove the head (caller guarantees !empty); dout is the
//                    current head, valid whenever !empty
//   flush            drop every entry; wins over push/pop
//   full, empty      occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module result_fifo #(
   parameter int WIDTH   = 36,
   parameter int DEPTH   = 2,
   parameter int PTR_BIT = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_BIT:0] FULL_COUNT = DEPTH[PTR_BIT:0];

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_BIT-1:0] wr_ptr;
   logic [PTR_BIT-1:0] rd_ptr;
   logic [PTR_BIT:0]   count;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage carries no reset; an entry is only ever read after the
   // count says it was written, so clearing it would cost logic for nothing.
   always_ff @(posedge clk_in) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus between the ALU and the LSB. Each source pushes
// results into its own FIFO; one head per cycle is popped round-robin and
// broadcast from registers.
//   clk_in, rst_in, rdy_in  clock, async active-high reset, global enable
//   rob_clear_up            misprediction flush: empties both FIFOs
//   alu_*                   ALU result in (tag, value, next_pc) / alu_ready
//   lsb_*                   LSB result in (tag, value) / lsb_ready
//   cdb_*                   registered broadcast; cdb_next_pc is 0 for LSB,
//                           cdb_src 0 = ALU, 1 = LSB
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_BIT    = DEF_ROB_BIT,
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
   parameter int PTR_BIT    = 1
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               rob_clear_up,
   input  logic               alu_valid,
   input  logic [ROB_BIT-1:0] alu_rob_entry,
   input  logic [31:0]        alu_value,
   input  logic [31:0]        alu_next_pc,
   output logic               alu_ready,
   input  logic               lsb_valid,
   input  logic [ROB_BIT-1:0] lsb_rob_entry,
   input  logic [31:0]        lsb_value,
   output logic               lsb_ready,
   output logic               cdb_valid,
   output logic [ROB_BIT-1:0] cdb_rob_entry,
   output logic [31:0]        cdb_value,
   output logic [31:0]        cdb_next_pc,
   output logic               cdb_src
);

   localparam int ALU_W = ROB_BIT + 64;
   localparam int LSB_W = ROB_BIT + 32;

   logic [ALU_W-1:0] alu_din, alu_dout;
   logic [LSB_W-1:0] lsb_din, lsb_dout;
   logic             alu_full, alu_empty, lsb_full, lsb_empty;
   logic             active, flush;
   logic             alu_push, lsb_push, alu_pop, lsb_pop;
   logic             any_head;
   src_e             winner;
   src_e             last_grant;

   assign active = rdy_in && !rob_clear_up;
   assign flush  = rdy_in &&  rob_clear_up;

   // Ready looks only at registered occupancy: a full FIFO refuses a push even
   // when its head leaves on the same edge.
   assign alu_ready = active && !alu_full;
   assign lsb_ready = active && !lsb_full;
   assign alu_push  = alu_valid && alu_ready;
   assign lsb_push  = lsb_valid && lsb_ready;

   assign any_head = !alu_empty || !lsb_empty;
   assign winner   = pick_source(!alu_empty, !lsb_empty, last_grant);
   assign alu_pop  = active && any_head && (winner == SRC_ALU);
   assign lsb_pop  = active && any_head && (winner == SRC_LSB);

   assign alu_din = {alu_rob_entry, alu_value, alu_next_pc};
   assign lsb_din = {lsb_rob_entry, lsb_value};

   result_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH), .PTR_BIT(PTR_BIT)) u_alu_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (alu_push),
      .pop    (alu_pop),
      .flush  (flush),
      .din    (alu_din),
      .dout   (alu_dout),
      .full   (alu_full),
      .empty  (alu_empty)
   );

   result_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH), .PTR_BIT(PTR_BIT)) u_lsb_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (lsb_push),
      .pop    (lsb_pop),
      .flush  (flush),
      .din    (lsb_din),
      .dout   (lsb_dout),
      .full   (lsb_full),
      .empty  (lsb_empty)
   );

   // Broadcast register. With rdy_in low everything holds so downstream
   // consumers, which also gate on rdy_in, see each broadcast exactly once.
   // The payload fields hold when nothing is granted; only cdb_valid drops.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_grant    <= SRC_LSB;
         cdb_valid     <= 1'b0;
         cdb_rob_entry <= '0;
         cdb_value     <= '0;
         cdb_next_pc   <= '0;
         cdb_src       <= SRC_ALU;
      end else if (rdy_in) begin
         if (rob_clear_up || !any_head) begin
            cdb_valid <= 1'b0;
         end else begin
            last_grant <= winner;
            cdb_valid  <= 1'b1;
            cdb_src    <= winner;
            if (winner == SRC_LSB) begin
               cdb_rob_entry <= lsb_dout[LSB_W-1:32];
               cdb_value     <= lsb_dout[31:0];
               cdb_next_pc   <= '0;
            end else begin
               cdb_rob_entry <= alu_dout[ALU_W-1:64];
               cdb_value     <= alu_dout[63:32];
               cdb_next_pc   <= alu_dout[31:0];
            end
         end
      end
   end

endmodule
